// File: rtl/ctrl_seq.sv
// ctrl_seq: microcoded-style control sequencer for a simple accumulator CPU.
// Fetches an instruction (PC -> MAR -> MEM -> MDR -> IR), decodes it and
// steps the datapath through the execute cycles, driving registered strobes.
//
// Parameters:
//   IW  instruction width; opcode = inst[IW-1:IW-3], mode = inst[IW-4:IW-5]
//   AW  operand width; operand = inst[AW-1:0], must satisfy AW <= IW-5
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   run        level; permits starting/continuing instruction fetch
//   inst       current IR contents, sampled in DEC
//   mem_ready  completes the current memory read/write
//   ctl        registered datapath strobes:
//              [0]pc_rd [1]pc_wr [2]pc_inc [3]mar_rd [4]mar_wr [5]mem_rd
//              [6]mem_wr [7]mdr_rd [8]mdr_wr_mem [9]mdr_wr_bus [10]ir_rd
//              [11]ir_wr [12]ac_rd [13]ac_wr [14]alu_en
//   alu_op     000 pass A, 001 pass B, 011 A+B, 100 A-B
//   state      current FSM state encoding (debug)
//   halted     high while in HALT
//   illegal    one-cycle pulse in DEC for an undecodable opcode/mode pair
//
// Build option: define CTRL_SEQ_INDIRECT_EN to make mode 10 an indirect
// addressing mode (EX_ADR -> EX_MEM -> EX_IND -> EX_MEM -> EX_ALU/EX_ST);
// without it mode 10 is illegal.

module ctrl_seq #(
    parameter int IW = 18,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [IW-1:0] inst,
    input  logic          mem_ready,
    output logic [14:0]   ctl,
    output logic [2:0]    alu_op,
    output logic [3:0]    state,
    output logic          halted,
    output logic          illegal
);

    generate
        if (AW > IW - 5) begin : g_aw_check
            $error("ctrl_seq: AW must not exceed IW-5");
        end
    endgenerate

`ifdef CTRL_SEQ_INDIRECT_EN
    localparam bit P_INDIRECT = 1'b1;
`else
    localparam bit P_INDIRECT = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADR  = 4'd1,
        S_F_MEM  = 4'd2,
        S_F_IR   = 4'd3,
        S_DEC    = 4'd4,
        S_EX_ADR = 4'd5,
        S_EX_MEM = 4'd6,
        S_EX_IND = 4'd7,
        S_EX_ALU = 4'd8,
        S_EX_ST  = 4'd9,
        S_EX_WR  = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000, OP_LOAD = 3'b001, OP_STORE = 3'b010,
                           OP_JMP = 3'b011, OP_SUB  = 3'b100, OP_HALT  = 3'b111;

    localparam int PC_RD = 0, PC_WR = 1, PC_INC = 2, MAR_RD = 3, MAR_WR = 4,
                   MEM_RD = 5, MEM_WR = 6, MDR_RD = 7, MDR_WR_MEM = 8,
                   MDR_WR_BUS = 9, IR_RD = 10, IR_WR = 11, AC_RD = 12,
                   AC_WR = 13, ALU_EN = 14;

    state_t        r_state, w_next, w_disp, w_end;
    logic [IW-1:0] r_inst, w_cur;
    logic          r_ind_done;
    logic [14:0]   r_ctl, w_ctl_nx;
    logic [2:0]    r_alu_op, w_aluop_nx, w_op;
    logic [1:0]    w_mode;
    logic          r_halted, r_illegal, w_halt_nx, w_ill_nx;
    logic          w_ill, w_ind, w_mem_mode, w_store;
    logic          w_unused_operand;

    // Outputs are registered from the next state, so the instruction that
    // decides them must be visible one cycle early: while in F_IR/DEC the live
    // IR is used, afterwards the copy latched in DEC.
    assign w_cur  = (r_state == S_F_IR || r_state == S_DEC) ? inst : r_inst;
    assign w_op   = w_cur[IW-1 -: 3];
    assign w_mode = w_cur[IW-4 -: 2];
    assign w_ind      = P_INDIRECT && (w_mode == 2'b10);
    assign w_mem_mode = (w_mode == 2'b01) || w_ind;
    assign w_store    = (w_op == OP_STORE);
    assign w_end      = run ? S_F_ADR : S_IDLE;
    assign w_unused_operand = ^r_inst[IW-6:0];

    // Instruction decode: dispatch target and legality
    always_comb begin
        w_disp = S_IDLE;
        w_ill  = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_LOAD: begin
                if (w_mode == 2'b00)  w_disp = S_EX_ALU;
                else if (w_mem_mode)  w_disp = S_EX_ADR;
                else                  w_ill  = 1'b1;
            end
            OP_STORE: begin
                if (w_mem_mode) w_disp = S_EX_ADR;
                else            w_ill  = 1'b1;
            end
            OP_JMP: begin
                if (w_mode == 2'b00) w_disp = S_EX_ALU;
                else                 w_ill  = 1'b1;
            end
            OP_HALT: begin
                if (w_mode[1] == 1'b0) w_disp = S_HALT;
                else                   w_ill  = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_F_ADR;
            S_F_ADR:  w_next = S_F_MEM;
            S_F_MEM:  if (mem_ready) w_next = S_F_IR;
            S_F_IR:   w_next = S_DEC;
            S_DEC:    w_next = w_ill ? w_end : w_disp;
            S_EX_ADR: w_next = (w_store && !w_ind) ? S_EX_ST : S_EX_MEM;
            S_EX_MEM: begin
                if (mem_ready) begin
                    if (w_ind && !r_ind_done) w_next = S_EX_IND;
                    else if (w_store)         w_next = S_EX_ST;
                    else                      w_next = S_EX_ALU;
                end
            end
            S_EX_IND: w_next = S_EX_MEM;
            S_EX_ALU: w_next = w_end;
            S_EX_ST:  w_next = S_EX_WR;
            S_EX_WR:  if (mem_ready) w_next = w_end;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore outputs for the state being entered
    always_comb begin
        w_ctl_nx   = '0;
        w_aluop_nx = 3'b000;
        w_halt_nx  = 1'b0;
        w_ill_nx   = 1'b0;
        case (w_next)
            S_F_ADR: begin
                w_ctl_nx[PC_RD] = 1'b1; w_ctl_nx[ALU_EN] = 1'b1; w_ctl_nx[MAR_WR] = 1'b1;
            end
            S_F_MEM, S_EX_MEM: begin
                w_ctl_nx[MAR_RD] = 1'b1; w_ctl_nx[MEM_RD] = 1'b1; w_ctl_nx[MDR_WR_MEM] = 1'b1;
            end
            S_F_IR: begin
                w_ctl_nx[MDR_RD] = 1'b1; w_ctl_nx[ALU_EN] = 1'b1; w_ctl_nx[IR_WR] = 1'b1;
                w_ctl_nx[PC_INC] = 1'b1; w_aluop_nx = 3'b001;
            end
            S_DEC: w_ill_nx = w_ill;
            S_EX_ADR: begin
                w_ctl_nx[IR_RD] = 1'b1; w_ctl_nx[ALU_EN] = 1'b1; w_ctl_nx[MAR_WR] = 1'b1;
                w_aluop_nx = 3'b001;
            end
            S_EX_IND: begin
                w_ctl_nx[MDR_RD] = 1'b1; w_ctl_nx[ALU_EN] = 1'b1; w_ctl_nx[MAR_WR] = 1'b1;
                w_aluop_nx = 3'b001;
            end
            S_EX_ALU: begin
                w_ctl_nx[ALU_EN] = 1'b1;
                if (w_op == OP_JMP) begin
                    w_ctl_nx[IR_RD] = 1'b1; w_ctl_nx[PC_WR] = 1'b1; w_aluop_nx = 3'b001;
                end else begin
                    w_ctl_nx[AC_RD] = 1'b1; w_ctl_nx[AC_WR] = 1'b1;
                    if (w_mode == 2'b00) w_ctl_nx[IR_RD]  = 1'b1;
                    else                 w_ctl_nx[MDR_RD] = 1'b1;
                    case (w_op)
                        OP_ADD:  w_aluop_nx = 3'b011;
                        OP_SUB:  w_aluop_nx = 3'b100;
                        default: w_aluop_nx = 3'b001;
                    endcase
                end
            end
            S_EX_ST: begin
                w_ctl_nx[AC_RD] = 1'b1; w_ctl_nx[ALU_EN] = 1'b1; w_ctl_nx[MDR_WR_BUS] = 1'b1;
            end
            S_EX_WR: begin
                w_ctl_nx[MAR_RD] = 1'b1; w_ctl_nx[MDR_RD] = 1'b1; w_ctl_nx[MEM_WR] = 1'b1;
            end
            S_HALT:  w_halt_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctl      <= '0;
            r_alu_op   <= 3'b000;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
            r_inst     <= '0;
            r_ind_done <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctl     <= w_ctl_nx;
            r_alu_op  <= w_aluop_nx;
            r_halted  <= w_halt_nx;
            r_illegal <= w_ill_nx;
            if (r_state == S_DEC) begin
                r_inst     <= inst;
                r_ind_done <= 1'b0;
            end
            if (r_state == S_EX_IND) r_ind_done <= 1'b1;
        end
    end

    assign ctl     = r_ctl;
    assign alu_op  = r_alu_op;
    assign state   = r_state;
    assign halted  = r_halted;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-vector scoreboard bench for ctrl_seq: each stimulus step pushes
// the expected state/strobes for the cycle it produces; a negedge monitor
// pops and compares.
module tb_ctrl_seq;

    localparam logic [3:0] IDLE = 4'd0, F_ADR = 4'd1, F_MEM = 4'd2, F_IR = 4'd3,
                           DEC = 4'd4, EX_ADR = 4'd5, EX_MEM = 4'd6, EX_IND = 4'd7,
                           EX_ALU = 4'd8, EX_ST = 4'd9, EX_WR = 4'd10, HALT = 4'd11;

    localparam logic [14:0] C_FADR  = 15'h4011, C_FMEM = 15'h0128, C_FIR  = 15'h4884,
                            C_EXADR = 15'h4410, C_ALUL = 15'h7400, C_ALUM = 15'h7080,
                            C_JMP   = 15'h4402, C_EXST = 15'h5200, C_EXWR = 15'h00C8,
                            C_EXIND = 15'h4090;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [2:0]  op;
        logic        h;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready;
    logic [17:0] inst;
    logic [14:0] ctl;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        halted, illegal;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_step  = 0;

    ctrl_seq #(.IW(18), .AW(13)) dut (
        .clk(clk), .reset(reset), .run(run), .inst(inst), .mem_ready(mem_ready),
        .ctl(ctl), .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_tests++;
            if ({state, ctl, alu_op, halted, illegal} !== m_e) begin
                n_fail++;
                $display("FAIL step%0d: got st=%0d ctl=%h op=%b h=%b il=%b, exp st=%0d ctl=%h op=%b h=%b il=%b",
                         n_step, state, ctl, alu_op, halted, illegal,
                         m_e.st, m_e.ctl, m_e.op, m_e.h, m_e.il);
            end
            n_step++;
        end
    end

    task automatic cyc(input logic r, input logic m, input logic [3:0] st,
                       input logic [14:0] c, input logic [2:0] o,
                       input logic h, input logic il);
        exp_t e;
        run = r;
        mem_ready = m;
        e = '{st: st, ctl: c, op: o, h: h, il: il};
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Called while in F_ADR; runs F_MEM, F_IR, DEC
    task automatic fetch(input logic [17:0] ins, input logic exp_ill);
        inst = ins;
        cyc(1'b1, 1'b1, F_MEM, C_FMEM, 3'b000, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, F_IR,  C_FIR,  3'b001, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, DEC,   '0,     3'b000, 1'b0, exp_ill);
    endtask

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; inst = '0;
        cyc(0, 0, IDLE, '0, 3'b000, 0, 0);
        cyc(1, 1, IDLE, '0, 3'b000, 0, 0);
        reset = 1'b0;
        cyc(0, 1, IDLE,  '0,     3'b000, 0, 0);
        cyc(1, 0, F_ADR, C_FADR, 3'b000, 0, 0);

        // ADD literal 5
        fetch({3'b000, 2'b00, 13'd5}, 1'b0);
        cyc(1, 1, EX_ALU, C_ALUL, 3'b011, 0, 0);
        cyc(1, 1, F_ADR,  C_FADR, 3'b000, 0, 0);

        // LOAD direct 0x40, three wait cycles, run dropped mid-instruction
        fetch({3'b001, 2'b01, 13'h0040}, 1'b0);
        cyc(0, 1, EX_ADR, C_EXADR, 3'b001, 0, 0);
        cyc(0, 0, EX_MEM, C_FMEM,  3'b000, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, EX_MEM, C_FMEM, 3'b000, 0, 0);
        cyc(0, 1, EX_ALU, C_ALUM, 3'b001, 0, 0);
        cyc(0, 1, IDLE,   '0,     3'b000, 0, 0);
        cyc(1, 0, F_ADR,  C_FADR, 3'b000, 0, 0);

        // STORE direct 0x10
        fetch({3'b010, 2'b01, 13'h0010}, 1'b0);
        cyc(1, 0, EX_ADR, C_EXADR, 3'b001, 0, 0);
        cyc(1, 1, EX_ST,  C_EXST,  3'b000, 0, 0);
        cyc(1, 1, EX_WR,  C_EXWR,  3'b000, 0, 0);
        cyc(1, 0, EX_WR,  C_EXWR,  3'b000, 0, 0);
        cyc(1, 1, F_ADR,  C_FADR,  3'b000, 0, 0);

        // JMP literal
        fetch({3'b011, 2'b00, 13'h0123}, 1'b0);
        cyc(1, 1, EX_ALU, C_JMP,  3'b001, 0, 0);
        cyc(1, 1, F_ADR,  C_FADR, 3'b000, 0, 0);

        // SUB literal 3
        fetch({3'b100, 2'b00, 13'd3}, 1'b0);
        cyc(1, 1, EX_ALU, C_ALUL, 3'b100, 0, 0);
        cyc(1, 1, F_ADR,  C_FADR, 3'b000, 0, 0);

        // Undefined opcode 101
        fetch({3'b101, 2'b00, 13'd7}, 1'b1);
        cyc(1, 1, F_ADR, C_FADR, 3'b000, 0, 0);

        // STORE literal is illegal; run low ends in IDLE
        fetch({3'b010, 2'b00, 13'd1}, 1'b1);
        cyc(0, 1, IDLE,  '0,     3'b000, 0, 0);
        cyc(1, 0, F_ADR, C_FADR, 3'b000, 0, 0);

        // ADD mode 10
`ifdef CTRL_SEQ_INDIRECT_EN
        fetch({3'b000, 2'b10, 13'h0020}, 1'b0);
        cyc(1, 0, EX_ADR, C_EXADR, 3'b001, 0, 0);
        cyc(1, 1, EX_MEM, C_FMEM,  3'b000, 0, 0);
        cyc(1, 1, EX_IND, C_EXIND, 3'b001, 0, 0);
        cyc(1, 0, EX_MEM, C_FMEM,  3'b000, 0, 0);
        cyc(1, 1, EX_ALU, C_ALUM,  3'b011, 0, 0);
        cyc(1, 1, F_ADR,  C_FADR,  3'b000, 0, 0);
`else
        fetch({3'b000, 2'b10, 13'h0020}, 1'b1);
        cyc(1, 1, F_ADR, C_FADR, 3'b000, 0, 0);
`endif

        // LOAD mode 11 is always illegal
        fetch({3'b001, 2'b11, 13'h0005}, 1'b1);
        cyc(1, 1, F_ADR, C_FADR, 3'b000, 0, 0);

        // HALT persists
        fetch({3'b111, 2'b00, 13'd0}, 1'b0);
        for (int i = 0; i < 21; i++) cyc(1, 1, HALT, '0, 3'b000, 1, 0);

        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("halt_reset_async", {state, ctl, alu_op, halted, illegal}, 24'h0);
        cyc(1, 0, IDLE, '0, 3'b000, 0, 0);
        reset = 1'b0;
        cyc(1, 0, F_ADR, C_FADR, 3'b000, 0, 0);
        cyc(1, 0, F_MEM, C_FMEM, 3'b000, 0, 0);

        // Reset mid-handshake in F_MEM
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("fmem_reset_async", {state, ctl, alu_op, halted, illegal}, 24'h0);
        cyc(0, 0, IDLE, '0, 3'b000, 0, 0);
        reset = 1'b0;
        cyc(0, 1, IDLE, '0, 3'b000, 0, 0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
